// File: rtl/ttt_pkg.sv
// Shared encodings for the tic-tac-toe turn controller: cell codes, FSM states, winner codes.
// Consumed by game_turn_ctrl and win_line_chk.
package ttt_pkg;

   typedef logic [1:0] cell_t;

   localparam cell_t CELL_EMPTY = 2'b00;
   localparam cell_t CELL_P1    = 2'b01;
   localparam cell_t CELL_P2    = 2'b10;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_P1_TURN = 3'd1;
   localparam logic [2:0] ST_P2_TURN = 3'd2;
   localparam logic [2:0] ST_EVAL    = 3'd3;
   localparam logic [2:0] ST_WIN     = 3'd4;
   localparam logic [2:0] ST_DRAW    = 3'd5;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   localparam logic [1:0] TURN_NONE = 2'b00;

   function automatic logic board_full(input logic [17:0] b);
      logic full;
      full = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (b[2*i +: 2] == CELL_EMPTY) full = 1'b0;
      end
      return full;
   endfunction

   function automatic logic is_onehot9(input logic [8:0] v);
      return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
   endfunction

endpackage

// File: rtl/win_line_chk.sv
// Combinational three-in-a-row detector: flags when any row, column or diagonal
// is fully owned by the given player code.
module win_line_chk
   import ttt_pkg::*;
(
   input  logic [17:0] board,
   input  cell_t       player,
   output logic        line
);

   logic [8:0] own;

   always_comb begin
      own = '0;
      for (int i = 0; i < 9; i++) begin
         own[i] = (player != CELL_EMPTY) && (board[2*i +: 2] == player);
      end
   end

   assign line = (own[0] & own[1] & own[2]) |
                 (own[3] & own[4] & own[5]) |
                 (own[6] & own[7] & own[8]) |
                 (own[0] & own[3] & own[6]) |
                 (own[1] & own[4] & own[7]) |
                 (own[2] & own[5] & own[8]) |
                 (own[0] & own[4] & own[8]) |
                 (own[2] & own[4] & own[6]);

endmodule

// File: rtl/game_turn_ctrl.sv
// Tic-tac-toe turn controller: arbitrates moves, keeps the board, detects win/draw.
// Optional per-turn forfeit timer is built only when MOVE_TIMEOUT_EN is defined.
//
// state      | meaning
// -----------+---------------------------------------------------
// IDLE       | no game active, requests ignored
// P1_TURN    | waiting for a player 1 move
// P2_TURN    | waiting for a player 2 move
// EVAL       | one cycle: check lines / full board for the mover
// WIN        | game over with a winner, held until new_game
// DRAW       | game over with full board, held until new_game
module game_turn_ctrl
   import ttt_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        new_game,
   input  logic        p1_valid,
   input  logic [8:0]  p1_sel,
   input  logic        p2_valid,
   input  logic [8:0]  p2_sel,
   output logic [17:0] board,
   output logic [1:0]  turn,
   output logic        move_ack,
   output logic        ill_move,
   output logic        game_over,
   output logic [1:0]  winner
);

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   logic [2:0] state;
   logic       cur_valid;
   logic [8:0] cur_sel;
   cell_t      mover;
   cell_t      other;
   logic       occupied;
   logic       legal;
   logic       line_hit;
   logic       full;

`ifdef MOVE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] timer;
`endif

   // In EVAL the mover is whoever still owns the turn output.
   always_comb begin
      cur_valid = 1'b0;
      cur_sel   = '0;
      mover     = turn;
      case (state)
         ST_P1_TURN: begin
            cur_valid = p1_valid;
            cur_sel   = p1_sel;
            mover     = CELL_P1;
         end
         ST_P2_TURN: begin
            cur_valid = p2_valid;
            cur_sel   = p2_sel;
            mover     = CELL_P2;
         end
         default: ;
      endcase
      other    = (mover == CELL_P1) ? CELL_P2 : CELL_P1;
      occupied = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (cur_sel[i] && (board[2*i +: 2] != CELL_EMPTY)) occupied = 1'b1;
      end
      legal = cur_valid && is_onehot9(cur_sel) && !occupied;
   end

   assign full = board_full(board);

   win_line_chk u_win_line_chk (
      .board  (board),
      .player (mover),
      .line   (line_hit)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         board     <= '0;
         turn      <= TURN_NONE;
         move_ack  <= 1'b0;
         ill_move  <= 1'b0;
         game_over <= 1'b0;
         winner    <= WIN_NONE;
`ifdef MOVE_TIMEOUT_EN
         timer     <= '0;
`endif
      end else begin
         move_ack <= 1'b0;
         ill_move <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
         timer    <= '0;
`endif
         if (new_game) begin
            state     <= ST_P1_TURN;
            board     <= '0;
            turn      <= CELL_P1;
            game_over <= 1'b0;
            winner    <= WIN_NONE;
         end else begin
            case (state)
               ST_P1_TURN, ST_P2_TURN: begin
                  if (legal) begin
                     for (int i = 0; i < 9; i++) begin
                        if (cur_sel[i]) board[2*i +: 2] <= mover;
                     end
                     move_ack <= 1'b1;
                     state    <= ST_EVAL;
                  end else begin
                     if (cur_valid) ill_move <= 1'b1;
`ifdef MOVE_TIMEOUT_EN
                     // Forfeit: turn passes on, board untouched, timer restarts.
                     if (timer == TIMEOUT_LAST) begin
                        ill_move <= 1'b1;
                        state    <= (mover == CELL_P1) ? ST_P2_TURN : ST_P1_TURN;
                        turn     <= other;
                     end else begin
                        timer <= timer + TW'(1);
                     end
`endif
                  end
               end
               ST_EVAL: begin
                  if (line_hit) begin
                     state     <= ST_WIN;
                     winner    <= mover;
                     game_over <= 1'b1;
                     turn      <= TURN_NONE;
                  end else if (full) begin
                     state     <= ST_DRAW;
                     winner    <= WIN_DRAW;
                     game_over <= 1'b1;
                     turn      <= TURN_NONE;
                  end else begin
                     state <= (mover == CELL_P1) ? ST_P2_TURN : ST_P1_TURN;
                     turn  <= other;
                  end
               end
               ST_IDLE, ST_WIN, ST_DRAW: ;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Scoreboard bench for game_turn_ctrl: a game-level reference model predicts each
// ack/reject pulse and the post-evaluation outcome; a monitor pops and compares.
module tb_game_turn_ctrl;

   localparam int TO = 8;

   logic        clk;
   logic        rst_n;
   logic        new_game;
   logic        p1_valid;
   logic [8:0]  p1_sel;
   logic        p2_valid;
   logic [8:0]  p2_sel;
   logic [17:0] board;
   logic [1:0]  turn;
   logic        move_ack;
   logic        ill_move;
   logic        game_over;
   logic [1:0]  winner;

   game_turn_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .new_game  (new_game),
      .p1_valid  (p1_valid),
      .p1_sel    (p1_sel),
      .p2_valid  (p2_valid),
      .p2_sel    (p2_sel),
      .board     (board),
      .turn      (turn),
      .move_ack  (move_ack),
      .ill_move  (ill_move),
      .game_over (game_over),
      .winner    (winner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          ack;
      logic [17:0] brd;
      logic [1:0]  trn;
      logic [1:0]  win;
      bit          go;
   } exp_t;

   exp_t pulse_q[$];
   exp_t eval_q[$];
   bit   eval_pending = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: phase 0 idle, 1 someone to move, 2 evaluating, 3 finished.
   int m_phase = 0;
   int m_cells[9];
   int m_player = 0;
   int m_winner = 0;
   int m_timer = 0;
   bit m_prev_acc = 1'b0;

   task automatic chk(input string nm, input logic [17:0] act, input logic [17:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [17:0] pack_board();
      logic [17:0] b;
      b = '0;
      for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_cells[i]);
      return b;
   endfunction

   function automatic bit has_line(input int p);
      int ln[8][3];
      ln = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
      for (int k = 0; k < 8; k++) begin
         if (m_cells[ln[k][0]] == p && m_cells[ln[k][1]] == p && m_cells[ln[k][2]] == p) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic bit all_full();
      for (int i = 0; i < 9; i++) if (m_cells[i] == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic exp_t snapshot(input bit ack);
      exp_t e;
      e.ack = ack;
      e.brd = pack_board();
      e.trn = (m_phase == 1 || m_phase == 2) ? 2'(m_player) : 2'b00;
      e.win = 2'(m_winner);
      e.go  = (m_phase == 3);
      return e;
   endfunction

   task automatic model_step();
      bit          push_eval;
      bit          v;
      logic [8:0]  s;
      int          idx;
      bit          fire;
      push_eval  = m_prev_acc;
      m_prev_acc = 1'b0;
      if (!rst_n) begin
         m_phase = 0; m_player = 0; m_winner = 0; m_timer = 0;
         for (int i = 0; i < 9; i++) m_cells[i] = 0;
      end else if (new_game) begin
         m_phase = 1; m_player = 1; m_winner = 0; m_timer = 0;
         for (int i = 0; i < 9; i++) m_cells[i] = 0;
      end else if (m_phase == 1) begin
         v   = (m_player == 1) ? p1_valid : p2_valid;
         s   = (m_player == 1) ? p1_sel : p2_sel;
         idx = 0;
         for (int i = 0; i < 9; i++) if (s[i]) idx = i;
         if (v && $countones(s) == 1 && m_cells[idx] == 0) begin
            m_cells[idx] = m_player;
            m_phase      = 2;
            m_prev_acc   = 1'b1;
            pulse_q.push_back(snapshot(1'b1));
         end else begin
            fire = 1'b0;
`ifdef MOVE_TIMEOUT_EN
            if (m_timer == TO - 1) begin
               fire     = 1'b1;
               m_player = 3 - m_player;
               m_timer  = 0;
            end else begin
               m_timer++;
            end
`endif
            if (v || fire) pulse_q.push_back(snapshot(1'b0));
         end
      end else if (m_phase == 2) begin
         if (has_line(m_player)) begin
            m_phase = 3; m_winner = m_player;
         end else if (all_full()) begin
            m_phase = 3; m_winner = 3;
         end else begin
            m_phase = 1; m_player = 3 - m_player; m_timer = 0;
         end
      end
      if (push_eval) eval_q.push_back(snapshot(1'b1));
   endtask

   task automatic cyc(input logic r, input logic ng, input logic v1, input logic [8:0] s1,
                      input logic v2, input logic [8:0] s2);
      @(negedge clk);
      rst_n = r; new_game = ng;
      p1_valid = v1; p1_sel = s1; p2_valid = v2; p2_sel = s2;
      model_step();
   endtask

   task automatic idle();
      cyc(1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000);
   endtask

   task automatic play(input int p, input logic [8:0] s);
      if (p == 1) cyc(1'b1, 1'b0, 1'b1, s, 1'b0, 9'h000);
      else        cyc(1'b1, 1'b0, 1'b0, 9'h000, 1'b1, s);
      idle();
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (eval_pending) begin
         eval_pending = 1'b0;
         if (eval_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL eval_outcome: acked move has no predicted outcome (t=%0t)", $time);
         end else begin
            e = eval_q.pop_front();
            chk("eval_turn", 18'(turn), 18'(e.trn));
            chk("eval_winner", 18'(winner), 18'(e.win));
            chk("eval_game_over", 18'(game_over), 18'(e.go));
         end
      end
      while (eval_q.size() != 0) begin
         e = eval_q.pop_front();
         n_checks++; n_errors++;
         $display("FAIL eval_outcome: expected accepted move not acked, outcome turn %0d (t=%0t)", e.trn, $time);
      end
      chk("ack_and_ill", 18'(move_ack & ill_move), 18'(0));
      chk("pulse_present", 18'(move_ack | ill_move), 18'(pulse_q.size() != 0));
      if ((move_ack || ill_move) && pulse_q.size() != 0) begin
         e = pulse_q.pop_front();
         chk("pulse_kind_ack", 18'(move_ack), 18'(e.ack));
         chk("pulse_board", board, e.brd);
         if (!e.ack) begin
            chk("ill_turn", 18'(turn), 18'(e.trn));
            chk("ill_winner", 18'(winner), 18'(e.win));
         end else if (move_ack) begin
            eval_pending = 1'b1;
         end
      end
      pulse_q.delete();
   end

   initial begin
      logic [8:0] s;
      rst_n = 1'b0; new_game = 1'b0;
      p1_valid = 1'b0; p1_sel = '0; p2_valid = 1'b0; p2_sel = '0;

      cyc(1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000);
      cyc(1'b0, 1'b1, 1'b1, 9'h001, 1'b0, 9'h000);
      settle();
      chk("rst_board", board, 18'h00000);
      chk("rst_turn", 18'(turn), 18'(2'b00));
      chk("rst_winner", 18'(winner), 18'(2'b00));
      chk("rst_game_over", 18'(game_over), 18'(0));
      chk("rst_pulses", 18'({move_ack, ill_move}), 18'(0));

      // First move, then an occupied-cell attempt by P2.
      cyc(1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 9'h000);
      play(1, 9'h001);
      settle();
      chk("first_move_board", board, 18'h00001);
      chk("first_move_turn", 18'(turn), 18'(2'b10));
      cyc(1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 9'h001);
      settle();
      chk("occupied_ill", 18'(ill_move), 18'(1));
      chk("occupied_board", board, 18'h00001);
      chk("occupied_turn", 18'(turn), 18'(2'b10));

      // P1 wins on the 1-5-9 diagonal; also a non-one-hot select and an off-turn request.
      play(2, 9'h002);
      cyc(1'b1, 1'b0, 1'b1, 9'h003, 1'b0, 9'h000);
      cyc(1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 9'h040);
      settle();
      chk("offturn_no_pulse", 18'({move_ack, ill_move}), 18'(0));
      play(1, 9'h010);
      play(2, 9'h004);
      play(1, 9'h100);
      settle();
      chk("win_winner", 18'(winner), 18'(2'b01));
      chk("win_game_over", 18'(game_over), 18'(1));
      chk("win_board", board, 18'h10129);
      cyc(1'b1, 1'b0, 1'b1, 9'h008, 1'b1, 9'h020);
      cyc(1'b1, 1'b0, 1'b1, 9'h040, 1'b1, 9'h080);
      settle();
      chk("win_hold_board", board, 18'h10129);
      chk("win_hold_winner", 18'(winner), 18'(2'b01));

      // Full-board draw: P1 1,3,4,8,9 / P2 2,5,6,7.
      cyc(1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 9'h000);
      play(1, 9'h001); play(2, 9'h002); play(1, 9'h004); play(2, 9'h010);
      play(1, 9'h008); play(2, 9'h020); play(1, 9'h080); play(2, 9'h040);
      play(1, 9'h100);
      idle(); idle();
      settle();
      chk("draw_winner", 18'(winner), 18'(2'b11));
      chk("draw_game_over", 18'(game_over), 18'(1));
      chk("draw_turn", 18'(turn), 18'(2'b00));

      // Reset in the middle of a game.
      cyc(1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 9'h000);
      play(1, 9'h010);
      cyc(1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 9'h001);
      cyc(1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 9'h000);
      settle();
      chk("midrst_board", board, 18'h00000);
      chk("midrst_turn", 18'(turn), 18'(2'b00));
      chk("midrst_winner", 18'(winner), 18'(2'b00));
      chk("midrst_game_over", 18'(game_over), 18'(0));
      idle();

`ifdef MOVE_TIMEOUT_EN
      cyc(1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 9'h000);
      for (int i = 0; i < TO; i++) idle();
      settle();
      chk("timeout_ill", 18'(ill_move), 18'(1));
      chk("timeout_turn", 18'(turn), 18'(2'b10));
      chk("timeout_board", board, 18'h00000);
`endif

      for (int n = 0; n < 4000; n++) begin
         logic r, ng, v1, v2;
         logic [8:0] s1, s2;
         r  = ($urandom_range(0, 599) != 0);
         if (m_phase == 0)      ng = ($urandom_range(0, 3) == 0);
         else if (m_phase == 3) ng = ($urandom_range(0, 5) == 0);
         else                   ng = ($urandom_range(0, 299) == 0);
         v1 = ($urandom_range(0, 2) != 0);
         v2 = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 9) < 8) s1 = 9'd1 << $urandom_range(0, 8);
         else                          s1 = 9'($urandom_range(0, 511));
         if ($urandom_range(0, 9) < 8) s2 = 9'd1 << $urandom_range(0, 8);
         else                          s2 = 9'($urandom_range(0, 511));
         cyc(r, ng, v1, s1, v2, s2);
      end
      idle(); idle(); idle();
      settle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/game_turn_ctrl.md
GAME_TURN_CTRL -- requirements
Module: game_turn_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 500_000_000; turn-timeout length in clk cycles, used only with MOVE_TIMEOUT_EN.
REQ-002 SHALL have port clk, input, 1, the single clock; every register updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port new_game, input, 1; a one-cycle pulse that clears the board and starts a game.
REQ-005 SHALL have port p1_valid, input, 1; player 1 move request.
REQ-006 SHALL have port p1_sel, input, 9; player 1 target cell, one-hot, bit0 = cell 1.
REQ-007 SHALL have port p2_valid, input, 1; player 2 move request.
REQ-008 SHALL have port p2_sel, input, 9; player 2 target cell, one-hot.
REQ-009 SHALL have port board, output, 18; cell k at bits [2k-1:2k-2], encoded 00 empty, 01 P1, 10 P2.
REQ-010 SHALL have port turn, output, 2; 01 = P1 to move, 10 = P2 to move, 00 = no game active.
REQ-011 SHALL have port move_ack, output, 1; one-cycle pulse when a move is accepted.
REQ-012 SHALL have port ill_move, output, 1; one-cycle pulse when a move is rejected.
REQ-013 SHALL have port game_over, output, 1; level, high in WIN or DRAW.
REQ-014 SHALL have port winner, output, 2; 01 = P1, 10 = P2, 11 = draw, 00 = none.

Function
REQ-015 SHALL implement the FSM states IDLE, P1_TURN, P2_TURN, EVAL, WIN and DRAW.
REQ-016 SHALL go IDLE -> P1_TURN on new_game; new_game in any state clears the board, winner and timer and enters P1_TURN the next cycle.
REQ-017 SHALL sample only the current player's valid/sel in P1_TURN or P2_TURN; the other player's request is ignored, with no pulse.
REQ-018 SHALL reject a request if sel is not exactly one-hot or the addressed cell is not 00: pulse ill_move the next cycle, leave the board unchanged and stay in the same turn state.
REQ-019 SHALL accept a legal request at cycle N: write the cell and pulse move_ack at N+1, and be in EVAL at N+1.
REQ-020 SHALL in EVAL (one cycle) check the 8 lines (3 rows, 3 columns, 2 diagonals) for the mover: a line found -> WIN; else all 9 cells non-empty -> DRAW; else switch to the other player's TURN.
REQ-021 SHALL present final winner and turn values at N+2.
REQ-022 SHALL hold WIN and DRAW until new_game; requests in IDLE, EVAL, WIN or DRAW are ignored.
REQ-023 SHALL count at most 9 accepted moves per game; a 10th accepted move is unreachable by construction.
REQ-024 SHALL never raise move_ack and ill_move in the same cycle.

Reset
REQ-025 SHALL on rst_n = 0 at a clk edge set: state IDLE, board 0, turn 00, move_ack 0, ill_move 0, game_over 0, winner 00, timer 0.
REQ-026 SHALL give rst_n priority over new_game; reset mid-game discards all board content.

Configuration
REQ-027 SHALL with MOVE_TIMEOUT_EN defined count cycles in P1_TURN/P2_TURN, clear the count on turn entry, and after TIMEOUT_CYCLES with no accepted move forfeit the turn: go to the other TURN state, no board change, ill_move pulsed once.
REQ-028 SHALL without MOVE_TIMEOUT_EN contain no timer logic and wait indefinitely in a TURN state.

Structure
REQ-029 SHALL place the cell encoding constants (EMPTY/P1/P2), the state encoding and the winner encoding in shared package ttt_pkg.
REQ-030 SHALL use one sub-module, win_line_chk: combinational, inputs board and player code, output is a 1-bit line-complete flag.

Verification
REQ-031 After reset, new_game, then p1_valid with p1_sel = 9'h001 -> move_ack at N+1, board = 18'h00001, turn = 10 at N+2.
REQ-032 P2 targets occupied cell 1 (p2_sel = 9'h001) -> ill_move pulse, board unchanged, turn remains 10.
REQ-033 A non-one-hot p1_sel = 9'h003 -> ill_move; p2_valid while turn = 01 -> ignored, no pulse.
REQ-034 P1 plays cells 1, 5, 9 interleaved with P2 plays 2, 3 -> winner = 01 and game_over = 1 two cycles after the third P1 move; further requests ignored.
REQ-035 A nine-move sequence with no line -> winner = 11, DRAW held; rst_n low mid-game -> all outputs return to reset values the next cycle.
REQ-036 With MOVE_TIMEOUT_EN and TIMEOUT_CYCLES = 8, no request in P1_TURN -> ill_move and turn = 10 after 8 cycles.
